rv_trap_ctrl: RTL
=================

// Module: rv_trap_ctrl
// PURPOSE
//  Parametrised machine-mode trap controller and PC register for the single-cycle RV32 core.
//  Captures NUM_IRQ edge-triggered interrupt lines and the illegal-instruction, ecall and mret
//  strobes, then selects the next PC. Holds mepc/mcause/mtvec/mask/MIE/MPIE state and
//  supports direct or vectored dispatch. Sits between next-PC logic and instruction fetch.
// PARAMETERS
//  XLEN         32            data/address width
//  NUM_IRQ      4             interrupt lines, 1..16
//  IRQ_BASE     16            cause code of irq[0]; irq[i] -> IRQ_BASE+i
//  RESET_PC     32'h0         pc after reset
//  MTVEC_RESET  32'h0         mtvec after reset (bits[1:0] forced 0)
//  VECTORED     1             1: interrupts go to mtvec+4*code; 0: all traps go to mtvec
// PORTS
//  clk        in   1        clock, rising edge
//  rst        in   1        asynchronous, active-high reset
//  irq        in   NUM_IRQ  interrupt requests, rising-edge sensitive
//  ill_instr  in   1        current instruction is illegal
//  ecall      in   1        current instruction is ecall
//  mret       in   1        current instruction is mret
//  pc_next    in   XLEN     sequential/branch next PC from datapath
//  csr_we     in   1        CSR write strobe
//  csr_sel    in   2        0 mtvec, 1 irq mask, 2 mepc, 3 reserved (ignored)
//  csr_wdata  in   XLEN     CSR write data
//  pc         out  XLEN     current PC (registered)
//  mepc       out  XLEN     saved return PC
//  mcause     out  XLEN     bit XLEN-1 = interrupt flag, low bits = code
//  mtvec      out  XLEN     trap base
//  irq_mask   out  NUM_IRQ  per-line enable
//  mie        out  1        global interrupt enable
//  trap_taken out  1        registered pulse: a trap was entered in the previous cycle
// BEHAVIOUR
//  Reset (async): pc=RESET_PC, mepc=0, mcause=0, mtvec=MTVEC_RESET&~3, irq_mask=all 1, mie=1,
//   mpie=1, pending=0, irq_q=0, trap_taken=0.
//  Edge capture: irq_q<=irq; pending[i] set when irq[i]&~irq_q[i]. Set beats clear when both
//   happen in the same cycle.
//  Eligible interrupt: pending & irq_mask & {mie}. The lowest index wins (fixed priority).
//  Event priority per cycle (exactly one applies):
//   1 mret: pc<=mepc; mie<=mpie; mpie<=1.
//   2 ill_instr: mepc<=pc; mcause<=2; pc<=mtvec; mpie<=mie; mie<=0.
//   3 ecall: mepc<=pc; mcause<=11; pc<=mtvec; mpie<=mie; mie<=0 (handler adds 4).
//   4 interrupt i: mepc<=pc_next; mcause<={1,IRQ_BASE+i}; clear pending[i]; mpie<=mie; mie<=0;
//     pc<= VECTORED ? mtvec+((IRQ_BASE+i)<<2) : mtvec. Sum is mod 2^XLEN.
//   5 otherwise: pc<=pc_next.
//  trap_taken<=1 only in cases 2-4.
//  Coincident strobes: mret+ill_instr -> mret only. ill_instr+ecall -> ill_instr.
//   An exception suppresses the interrupt that cycle; its pending bit stays set.
//  Nested trap inside a handler: exceptions are always taken and overwrite mepc/mcause.
//   Interrupts are blocked by mie=0 until mret.
//  CSR write: applied the same cycle. A trap's update of mepc wins over a csr write to mepc.
//   mtvec writes force bits[1:0]=0. A mask write takes effect for eligibility next cycle.
//  Pending bits for masked lines are retained; the interrupt is taken once unmasked.
//  Reset mid-handler discards all pending/saved state.
// STRUCTURE
//  Package rv_trap_pkg: CAUSE_ILL=2, CAUSE_ECALL_M=11, CSR_SEL_MTVEC/MASK/MEPC encodings.
//  Sub-module rv_irq_prio: edge capture + pending reg + priority encoder.
//   Outputs irq_valid and irq_idx; input irq_clr (one-hot).
//  Top holds pc/CSRs and the event-priority mux.
// TESTING
//  T1 reset: assert rst mid-cycle -> pc=0, mie=1, mask=4'hF, pending=0 immediately.
//  T2 irq[2] rise, pc=0x40, pc_next=0x44, VECTORED=1, mtvec=0x100
//   -> pc=0x148, mepc=0x44, mcause=0x80000012, mie=0, trap_taken=1.
//   mret -> pc=0x44, mie=1.
//  T3 irq[1] and irq[3] rise together -> irq1 taken first (pc=0x144).
//   After mret, irq3 taken (pc=0x14C).
//  T4 ill_instr+ecall+irq[0] in one cycle at pc=0x20
//   -> mcause=2, mepc=0x20, pc=mtvec; irq0 stays pending, taken after mret.
//  T5 mask=4'b1110, irq[0] rise -> no trap.
//   csr write mask=4'hF -> trap next cycle, mcause code 16.
//  T6 irq[0] re-rises in the cycle it is taken -> pending stays 1; second trap after mret.

Source files
------------

// File: rtl/rv_trap_pkg.sv
// Shared constants for the machine-mode trap controller: cause codes,
// CSR select encodings and the per-cycle event classification.
package rv_trap_pkg;

  localparam int CAUSE_ILL     = 2;
  localparam int CAUSE_ECALL_M = 11;

  localparam logic [1:0] CSR_SEL_MTVEC = 2'd0;
  localparam logic [1:0] CSR_SEL_MASK  = 2'd1;
  localparam logic [1:0] CSR_SEL_MEPC  = 2'd2;

  // Exactly one of these applies per cycle, listed in priority order.
  typedef enum logic [2:0] {
    EV_MRET,
    EV_ILL,
    EV_ECALL,
    EV_IRQ,
    EV_SEQ
  } trap_ev_e;

endpackage

// File: rtl/rv_trap_ctrl_if.sv
// Bundle of the trap controller's datapath-facing signals. The master side
// drives the strobes/CSR bus; the slave side is the controller itself.
interface rv_trap_ctrl_if #(
  parameter int XLEN    = 32,
  parameter int NUM_IRQ = 4
);
  logic [NUM_IRQ-1:0] irq_i;
  logic               ill_instr_i;
  logic               ecall_i;
  logic               mret_i;
  logic [XLEN-1:0]    pc_next_i;
  logic               csr_we_i;
  logic [1:0]         csr_sel_i;
  logic [XLEN-1:0]    csr_wdata_i;

  logic [XLEN-1:0]    pc_o;
  logic [XLEN-1:0]    mepc_o;
  logic [XLEN-1:0]    mcause_o;
  logic [XLEN-1:0]    mtvec_o;
  logic [NUM_IRQ-1:0] irq_mask_o;
  logic               mie_o;
  logic               trap_taken_o;
  logic [NUM_IRQ-1:0] pending_o;

  modport master (
    output irq_i, ill_instr_i, ecall_i, mret_i, pc_next_i,
           csr_we_i, csr_sel_i, csr_wdata_i,
    input  pc_o, mepc_o, mcause_o, mtvec_o, irq_mask_o, mie_o,
           trap_taken_o, pending_o
  );

  modport slave (
    input  irq_i, ill_instr_i, ecall_i, mret_i, pc_next_i,
           csr_we_i, csr_sel_i, csr_wdata_i,
    output pc_o, mepc_o, mcause_o, mtvec_o, irq_mask_o, mie_o,
           trap_taken_o, pending_o
  );
endinterface

// File: rtl/rv_irq_prio.sv
// Rising-edge interrupt capture into sticky pending bits, plus a fixed
// lowest-index-wins priority encoder over the enabled pending lines.
module rv_irq_prio #(
  parameter int NUM_IRQ = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_IRQ-1:0] irq_i,
  input  logic [NUM_IRQ-1:0] en_i,
  input  logic [NUM_IRQ-1:0] irq_clr_i,
  output logic               irq_valid_o,
  output logic [3:0]         irq_idx_o,
  output logic [NUM_IRQ-1:0] pending_o
);

  logic [NUM_IRQ-1:0] irq_q;
  logic [NUM_IRQ-1:0] pending_q, pending_d;
  logic [NUM_IRQ-1:0] eligible;

  // A new edge re-arms a line even in the cycle its previous request is serviced.
  assign pending_d = (pending_q & ~irq_clr_i) | (irq_i & ~irq_q);
  assign eligible  = pending_q & en_i;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      irq_q     <= '0;
      pending_q <= '0;
    end else begin
      irq_q     <= irq_i;
      pending_q <= pending_d;
    end
  end

  always_comb begin
    irq_valid_o = 1'b0;
    irq_idx_o   = '0;
    for (int i = NUM_IRQ - 1; i >= 0; i--) begin
      if (eligible[i]) begin
        irq_valid_o = 1'b1;
        irq_idx_o   = 4'(i);
      end
    end
  end

  assign pending_o = pending_q;

endmodule

// File: rtl/rv_trap_ctrl.sv
// Machine-mode trap controller and PC register: picks the next PC from
// mret / exception / interrupt / sequential flow and maintains the trap CSRs.
module rv_trap_ctrl
  import rv_trap_pkg::*;
#(
  parameter int              XLEN        = 32,
  parameter int              NUM_IRQ     = 4,
  parameter int              IRQ_BASE    = 16,
  parameter logic [XLEN-1:0] RESET_PC    = '0,
  parameter logic [XLEN-1:0] MTVEC_RESET = '0,
  parameter bit              VECTORED    = 1'b1
) (
  input logic         clk,
  input logic         rst,
  rv_trap_ctrl_if.slave bus
);

  logic [XLEN-1:0]    pc_q, pc_d;
  logic [XLEN-1:0]    mepc_q, mepc_d;
  logic [XLEN-1:0]    mcause_q, mcause_d;
  logic [XLEN-1:0]    mtvec_q, mtvec_d;
  logic [NUM_IRQ-1:0] mask_q, mask_d;
  logic               mie_q, mie_d;
  logic               mpie_q, mpie_d;
  logic               trap_q, trap_d;

  logic               irq_valid;
  logic [3:0]         irq_idx;
  logic [NUM_IRQ-1:0] irq_clr;
  logic [NUM_IRQ-1:0] pending;
  logic [XLEN-1:0]    irq_code;
  trap_ev_e           ev;

  rv_irq_prio #(.NUM_IRQ(NUM_IRQ)) u_prio (
    .clk         (clk),
    .rst         (rst),
    .irq_i       (bus.irq_i),
    .en_i        (mask_q & {NUM_IRQ{mie_q}}),
    .irq_clr_i   (irq_clr),
    .irq_valid_o (irq_valid),
    .irq_idx_o   (irq_idx),
    .pending_o   (pending)
  );

  always_comb begin
    if (bus.mret_i)           ev = EV_MRET;
    else if (bus.ill_instr_i) ev = EV_ILL;
    else if (bus.ecall_i)     ev = EV_ECALL;
    else if (irq_valid)       ev = EV_IRQ;
    else                      ev = EV_SEQ;
  end

  assign irq_code = XLEN'(IRQ_BASE) + XLEN'(irq_idx);

  // Only the line actually dispatched this cycle gets its pending bit cleared.
  generate
    for (genvar gi = 0; gi < NUM_IRQ; gi++) begin : g_clr
      assign irq_clr[gi] = (ev == EV_IRQ) && (irq_idx == 4'(gi));
    end
  endgenerate

  always_comb begin
    pc_d     = pc_q;
    mepc_d   = mepc_q;
    mcause_d = mcause_q;
    mtvec_d  = mtvec_q;
    mask_d   = mask_q;
    mie_d    = mie_q;
    mpie_d   = mpie_q;
    trap_d   = 1'b0;

    if (bus.csr_we_i) begin
      case (bus.csr_sel_i)
        CSR_SEL_MTVEC: mtvec_d = {bus.csr_wdata_i[XLEN-1:2], 2'b00};
        CSR_SEL_MASK:  mask_d  = bus.csr_wdata_i[NUM_IRQ-1:0];
        CSR_SEL_MEPC:  mepc_d  = bus.csr_wdata_i;
        default:       ;
      endcase
    end

    // Event updates come after the CSR write so a trap's mepc wins.
    case (ev)
      EV_MRET: begin
        pc_d   = mepc_q;
        mie_d  = mpie_q;
        mpie_d = 1'b1;
      end
      EV_ILL, EV_ECALL: begin
        mepc_d   = pc_q;
        mcause_d = (ev == EV_ILL) ? XLEN'(CAUSE_ILL) : XLEN'(CAUSE_ECALL_M);
        pc_d     = mtvec_q;
        mpie_d   = mie_q;
        mie_d    = 1'b0;
        trap_d   = 1'b1;
      end
      EV_IRQ: begin
        mepc_d   = bus.pc_next_i;
        mcause_d = {1'b1, irq_code[XLEN-2:0]};
        pc_d     = VECTORED ? (mtvec_q + (irq_code << 2)) : mtvec_q;
        mpie_d   = mie_q;
        mie_d    = 1'b0;
        trap_d   = 1'b1;
      end
      default: pc_d = bus.pc_next_i;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q     <= RESET_PC;
      mepc_q   <= '0;
      mcause_q <= '0;
      mtvec_q  <= {MTVEC_RESET[XLEN-1:2], 2'b00};
      mask_q   <= '1;
      mie_q    <= 1'b1;
      mpie_q   <= 1'b1;
      trap_q   <= 1'b0;
    end else begin
      pc_q     <= pc_d;
      mepc_q   <= mepc_d;
      mcause_q <= mcause_d;
      mtvec_q  <= mtvec_d;
      mask_q   <= mask_d;
      mie_q    <= mie_d;
      mpie_q   <= mpie_d;
      trap_q   <= trap_d;
    end
  end

  assign bus.pc_o         = pc_q;
  assign bus.mepc_o       = mepc_q;
  assign bus.mcause_o     = mcause_q;
  assign bus.mtvec_o      = mtvec_q;
  assign bus.irq_mask_o   = mask_q;
  assign bus.mie_o        = mie_q;
  assign bus.trap_taken_o = trap_q;
  assign bus.pending_o    = pending;

endmodule
